shared_line_arbiter: RTL and testbench

SHARED_LINE_ARBITER -- requirements
Module: shared_line_arbiter

---
 rtl/shared_line_pkg.sv | 14 +
 rtl/rr_pick.sv | 28 ++
 rtl/shared_line_arbiter.sv | 111 +++++++++++
 tb/tb_shared_line_arbiter.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/shared_line_pkg.sv
// Shared types and default sizing for the shared-line arbiter.
package shared_line_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } state_e;

    localparam int DEF_NUM_REQ  = 4;
    localparam int DEF_MAX_HOLD = 8;
    localparam int HOLD_W       = 8;

endpackage

// File: rtl/rr_pick.sv
// Round-robin selector: first requester after last_owner, wrapping around.
module rr_pick
    import shared_line_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_owner,
    output logic [NUM_REQ-1:0]         pick,
    output logic                       valid
);

    localparam int IDW = $clog2(NUM_REQ);

    always_comb begin
        pick  = '0;
        valid = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            logic [IDW-1:0] idx;
            idx = IDW'((int'(last_owner) + i) % NUM_REQ);
            if (!valid && req[idx]) begin
                pick[idx] = 1'b1;
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shared_line_arbiter.sv
// Round-robin owner arbitration of a single shared line, with bounded hold
// time, a one-cycle turnaround between owners, and a line-value override.
module shared_line_arbiter
    import shared_line_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         line_in,
    input  logic                       force_en,
    input  logic                       force_val,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       line_out,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] owner_id
);

    localparam int                IDW      = $clog2(NUM_REQ);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
    localparam logic [IDW-1:0]    LAST_RST = IDW'(NUM_REQ - 1);

    state_e              state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [IDW-1:0]      owner_q, owner_d;
    logic [IDW-1:0]      last_q, last_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                line_q, line_d;
    logic [NUM_REQ-1:0]  pick;
    logic                pick_vld;
    logic                others;

    function automatic logic [IDW-1:0] enc(input logic [NUM_REQ-1:0] oh);
        enc = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) enc = IDW'(i);
        end
    endfunction

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req        (req),
        .last_owner (last_q),
        .pick       (pick),
        .valid      (pick_vld)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        last_d  = last_q;
        hold_d  = hold_q;
        others  = |(req & ~grant_q);
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = OWN;
                    grant_d = pick;
                    owner_d = enc(pick);
                    hold_d  = HOLD_ONE;
                end
            end
            OWN: begin
                if (!req[owner_q] || (hold_q == HOLD_MAX && others)) begin
                    state_d = TURN;
                    grant_d = '0;
                    last_d  = owner_q;
                    hold_d  = '0;
                end else if (hold_q == HOLD_MAX) begin
                    // Nobody else waiting: renew the grant without a turnaround.
                    hold_d = HOLD_ONE;
                end else begin
                    hold_d = hold_q + HOLD_ONE;
                end
            end
            TURN:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Override only steers the line value; arbitration never sees it.
        if (force_en)              line_d = force_val;
        else if (state_q == OWN)   line_d = line_in[owner_q];
        else                       line_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            last_q  <= LAST_RST;
            hold_q  <= '0;
            line_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            line_q  <= line_d;
        end
    end

    assign grant    = grant_q;
    assign line_out = line_q;
    assign busy     = |grant_q;
    assign owner_id = busy ? owner_q : '0;

endmodule

// File: tb/tb_shared_line_arbiter.sv
// Directed bench for shared_line_arbiter (NUM_REQ=4, MAX_HOLD=8).
module tb_shared_line_arbiter;
    import shared_line_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] line_in = '0;
    logic       force_en = 1'b0;
    logic       force_val = 1'b0;
    logic [3:0] grant;
    logic       line_out;
    logic       busy;
    logic [1:0] owner_id;

    int n_cmp = 0;
    int n_err = 0;

    shared_line_arbiter #(.NUM_REQ(4), .MAX_HOLD(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .line_in   (line_in),
        .force_en  (force_en),
        .force_val (force_val),
        .grant     (grant),
        .line_out  (line_out),
        .busy      (busy),
        .owner_id  (owner_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] line_in;
        logic       fen;
        logic       fval;
        logic [3:0] grant;
        logic       line;
        logic       busy;
        logic [1:0] owner;
    } vec_t;

    vec_t tbl[17];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; line_in = '0; force_en = 1'b0; force_val = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    a_onehot: assert property (@(posedge clk) $onehot0(grant))
        else begin n_err++; $display("FAIL onehot0: grant=%b", grant); end
    a_busy: assert property (@(posedge clk) busy == (|grant))
        else begin n_err++; $display("FAIL busy_or: busy=%b grant=%b", busy, grant); end
    a_turn: assert property (@(posedge clk) disable iff (rst)
                             (dut.state_q == TURN) |-> (grant == '0) ##1 (grant == '0))
        else begin n_err++; $display("FAIL turn_grant: grant=%b", grant); end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1);
    end

    initial begin
        //          req      line_in  fen   fval  | grant    line  busy  owner
        tbl[0]  = '{4'b0101, 4'b0000, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b1, 2'd0};
        tbl[1]  = '{4'b0101, 4'b0001, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b1, 2'd0};
        tbl[2]  = '{4'b0100, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0};
        tbl[3]  = '{4'b0100, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0};
        tbl[4]  = '{4'b0100, 4'b0000, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b1, 2'd2};
        tbl[5]  = '{4'b0000, 4'b0100, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 2'd0};
        tbl[6]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0};
        tbl[7]  = '{4'b0010, 4'b0010, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b1, 2'd1};
        tbl[8]  = '{4'b0010, 4'b0010, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b1, 2'd1};
        tbl[9]  = '{4'b0010, 4'b0000, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b1, 2'd1};
        tbl[10] = '{4'b0010, 4'b0010, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b1, 2'd1};
        tbl[11] = '{4'b0010, 4'b0000, 1'b1, 1'b1, 4'b0010, 1'b1, 1'b1, 2'd1};
        tbl[12] = '{4'b0010, 4'b0010, 1'b1, 1'b0, 4'b0010, 1'b0, 1'b1, 2'd1};
        tbl[13] = '{4'b0010, 4'b0010, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b1, 2'd1};
        tbl[14] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0};
        tbl[15] = '{4'b0000, 4'b0000, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd0};
        tbl[16] = '{4'b0001, 4'b0000, 1'b1, 1'b1, 4'b0001, 1'b1, 1'b1, 2'd0};

        // Reset holds everything low even with requests and override active.
        rst = 1'b1; req = 4'b1111; line_in = 4'b1111; force_en = 1'b1; force_val = 1'b1;
        step();
        step();
        chk("rst grant", grant, 4'b0000);
        chk("rst line_out", line_out, 1'b0);
        chk("rst busy", busy, 1'b0);
        chk("rst owner_id", owner_id, 2'd0);
        do_reset();
        step();
        chk("post-rst idle grant", grant, 4'b0000);
        chk("post-rst idle line", line_out, 1'b0);

        for (int i = 0; i < 17; i++) begin
            req = tbl[i].req; line_in = tbl[i].line_in;
            force_en = tbl[i].fen; force_val = tbl[i].fval;
            step();
            chk($sformatf("row%0d grant", i), grant, tbl[i].grant);
            chk($sformatf("row%0d line_out", i), line_out, tbl[i].line);
            chk($sformatf("row%0d busy", i), busy, tbl[i].busy);
            chk($sformatf("row%0d owner_id", i), owner_id, tbl[i].owner);
        end

        // All requesting: 8-cycle tenures 0,1,2,3,0 separated by TURN + IDLE.
        do_reset();
        req = 4'b1111;
        step();
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < 8; c++) begin
                chk($sformatf("rr g%0d c%0d grant", g, c), grant, 4'b0001 << (g % 4));
                chk($sformatf("rr g%0d c%0d owner", g, c), owner_id, g % 4);
                step();
            end
            chk($sformatf("rr g%0d turn gap", g), grant, 4'b0000);
            step();
            chk($sformatf("rr g%0d idle gap", g), grant, 4'b0000);
            step();
        end
        chk("rr next after 0", grant, 4'b0010);

        // Lone requester keeps the grant through MAX_HOLD reloads.
        do_reset();
        req = 4'b0100;
        step();
        for (int c = 0; c < 20; c++) begin
            chk($sformatf("solo c%0d grant", c), grant, 4'b0100);
            step();
        end
        req = 4'b0000;
        step();
        chk("solo release", grant, 4'b0000);

        // Reset during ownership at hold count 3.
        do_reset();
        req = 4'b0100; line_in = 4'b0100;
        step();
        step();
        step();
        chk("midrst pre grant", grant, 4'b0100);
        chk("midrst pre line", line_out, 1'b1);
        rst = 1'b1;
        step();
        chk("midrst grant", grant, 4'b0000);
        chk("midrst line", line_out, 1'b0);
        chk("midrst busy", busy, 1'b0);
        rst = 1'b0; req = 4'b1000; line_in = '0;
        step();
        chk("midrst regrant", grant, 4'b1000);
        chk("midrst owner", owner_id, 2'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
